// File: rtl/usb_endpoint_out.sv
// Device-to-host endpoint: app fills a transactional byte buffer, PE pulls DATA0/1 packets on IN tokens.
// Latency: response strobe 1 cycle after token; first payload byte 2 cycles after token, then 1 byte per 2 cycles.
// Backpressure: full_o blocks app writes; unACKed bytes stay protected until ACK, timeout rewinds for retry.

package usb_packet_pkg;
  // Two-bit PID codes taken from PID[3:2] of the corresponding USB PID.
  localparam logic [1:0] RES_ACK   = 2'b00;
  localparam logic [1:0] RES_NYET  = 2'b01;
  localparam logic [1:0] RES_NAK   = 2'b10;
  localparam logic [1:0] RES_STALL = 2'b11;
  localparam logic [1:0] DATA0     = 2'b00;
  localparam logic [1:0] DATA1     = 2'b10;
endpackage

module usb_endpoint_out
  import usb_packet_pkg::*;
#(
  parameter int ADDR_WID        = 9,
  parameter int MAX_PACKET_SIZE = 64,
  parameter bit IS_ISOCHRONOUS  = 1'b0
) (
  input  logic       clk12_i,
  input  logic       rst_n_i,
  input  logic       resetDataToggle_i,
  input  logic       EP_OUT_fillTransDone_i,
  input  logic       EP_OUT_fillTransSuccess_i,
  input  logic       EP_OUT_dataValid_i,
  input  logic [7:0] EP_OUT_data_i,
  output logic       EP_OUT_full_o,
  input  logic       gotInToken_i,
  input  logic       EP_OUT_popData_i,
  output logic       EP_OUT_dataAvailable_o,
  output logic       EP_OUT_isLast_o,
  output logic [7:0] EP_OUT_data_o,
  input  logic       hostAck_i,
  input  logic       hostTimeout_i,
  output logic       respValid_o,
  output logic       respHandshakePID_o,
  output logic [1:0] respPacketID_o
);

  localparam int                  DEPTH   = 1 << ADDR_WID;
  localparam logic [ADDR_WID-1:0] MAX_LEN = ADDR_WID'(MAX_PACKET_SIZE);
  localparam logic [ADDR_WID-1:0] ONE     = ADDR_WID'(1);

  typedef enum logic [1:0] {IDLE, FETCH, SEND, WAIT_HS} state_t;

  state_t              state_q, state_d;
  logic [ADDR_WID-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WID-1:0] wr_commit_q, wr_commit_d;
  logic [ADDR_WID-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WID-1:0] rd_commit_q, rd_commit_d;
  logic [ADDR_WID-1:0] pkt_len_q, pkt_len_d;
  logic [ADDR_WID-1:0] byte_cnt_q, byte_cnt_d;
  logic                toggle_q, toggle_d;
  logic                resp_vld_q, resp_vld_d;
  logic                resp_hs_q, resp_hs_d;
  logic [1:0]          resp_pid_q, resp_pid_d;
  logic                data_avail_q, data_avail_d;
  logic                is_last_q, is_last_d;
  logic [7:0]          data_q, data_d;

  logic [7:0]          mem_q [DEPTH];
  logic                wr_en;
  logic [ADDR_WID-1:0] avail;

  // Full keeps one slot free and measures against rd_commit so un-ACKed bytes are never overwritten.
  assign EP_OUT_full_o = (wr_ptr_q + ONE) == rd_commit_q;
  assign avail         = wr_commit_q - rd_commit_q;

  // Fill side: write pointer advance, commit or discard of the current fill transaction.
  always_comb begin
    wr_en       = EP_OUT_dataValid_i && !EP_OUT_full_o &&
                  !(EP_OUT_fillTransDone_i && !EP_OUT_fillTransSuccess_i);
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    if (wr_en) wr_ptr_d = wr_ptr_q + ONE;
    if (EP_OUT_fillTransDone_i) begin
      if (EP_OUT_fillTransSuccess_i) wr_commit_d = wr_ptr_d;
      else                           wr_ptr_d    = wr_commit_q;
    end
  end

  // Payload storage, no reset needed.
  always_ff @(posedge clk12_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= EP_OUT_data_i;
  end

  // PE-side FSM: token response, byte fetch/send, handshake retire or rewind.
  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    rd_commit_d  = rd_commit_q;
    pkt_len_d    = pkt_len_q;
    byte_cnt_d   = byte_cnt_q;
    toggle_d     = toggle_q;
    resp_vld_d   = 1'b0;
    resp_hs_d    = 1'b0;
    resp_pid_d   = 2'b00;
    data_avail_d = data_avail_q;
    is_last_d    = is_last_q;
    data_d       = data_q;
    case (state_q)
      IDLE: begin
        if (gotInToken_i) begin
          resp_vld_d = 1'b1;
          if (avail == '0) begin
            resp_hs_d  = 1'b1;
            resp_pid_d = RES_NAK;
          end else begin
            pkt_len_d  = (avail > MAX_LEN) ? MAX_LEN : avail;
            byte_cnt_d = '0;
            resp_pid_d = (toggle_q && !IS_ISOCHRONOUS) ? DATA1 : DATA0;
            state_d    = FETCH;
          end
        end
      end
      FETCH: begin
        data_d       = mem_q[rd_ptr_q];
        data_avail_d = 1'b1;
        is_last_d    = (byte_cnt_q == pkt_len_q - ONE);
        state_d      = SEND;
      end
      SEND: begin
        if (EP_OUT_popData_i && data_avail_q) begin
          rd_ptr_d     = rd_ptr_q + ONE;
          byte_cnt_d   = byte_cnt_q + ONE;
          data_avail_d = 1'b0;
          is_last_d    = 1'b0;
          if (!is_last_q) begin
            state_d = FETCH;
          end else if (IS_ISOCHRONOUS) begin
            rd_commit_d = rd_ptr_q + ONE;
            state_d     = IDLE;
          end else begin
            state_d = WAIT_HS;
          end
        end
      end
      WAIT_HS: begin
        if (hostAck_i) begin
          rd_commit_d = rd_ptr_q;
          toggle_d    = !toggle_q;
          state_d     = IDLE;
        end else if (hostTimeout_i) begin
          rd_ptr_d = rd_commit_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Configuration event overrides any same-cycle toggle flip.
    if (resetDataToggle_i) toggle_d = 1'b0;
  end

  // State and output registers.
  always_ff @(posedge clk12_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      rd_ptr_q     <= '0;
      rd_commit_q  <= '0;
      pkt_len_q    <= '0;
      byte_cnt_q   <= '0;
      toggle_q     <= 1'b0;
      resp_vld_q   <= 1'b0;
      resp_hs_q    <= 1'b0;
      resp_pid_q   <= 2'b00;
      data_avail_q <= 1'b0;
      is_last_q    <= 1'b0;
      data_q       <= 8'h00;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_commit_q  <= rd_commit_d;
      pkt_len_q    <= pkt_len_d;
      byte_cnt_q   <= byte_cnt_d;
      toggle_q     <= toggle_d;
      resp_vld_q   <= resp_vld_d;
      resp_hs_q    <= resp_hs_d;
      resp_pid_q   <= resp_pid_d;
      data_avail_q <= data_avail_d;
      is_last_q    <= is_last_d;
      data_q       <= data_d;
    end
  end

  assign respValid_o            = resp_vld_q;
  assign respHandshakePID_o     = resp_hs_q;
  assign respPacketID_o         = resp_pid_q;
  assign EP_OUT_dataAvailable_o = data_avail_q;
  assign EP_OUT_isLast_o        = is_last_q;
  assign EP_OUT_data_o          = data_q;

endmodule

// File: tb/tb_usb_endpoint_out.sv
// Directed bench for usb_endpoint_out: two instances (default and 16-deep) share one stimulus.
// sel picks which instance's outputs are observed; expected bytes come from a queue filled alongside writes.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_usb_endpoint_out;
  import usb_packet_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, rtog, fill_done, fill_ok, wvld, tok, pop, ack, tout, sel;
  logic [7:0] wdat;

  logic       a_full, a_avail, a_last, a_rvld, a_rhs;
  logic [7:0] a_dat;
  logic [1:0] a_pid;
  logic       b_full, b_avail, b_last, b_rvld, b_rhs;
  logic [7:0] b_dat;
  logic [1:0] b_pid;

  logic       o_full, o_avail, o_last, o_rvld, o_rhs;
  logic [7:0] o_dat;
  logic [1:0] o_pid;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  usb_endpoint_out u_dut_a (
    .clk12_i(clk), .rst_n_i(rst_n), .resetDataToggle_i(rtog),
    .EP_OUT_fillTransDone_i(fill_done), .EP_OUT_fillTransSuccess_i(fill_ok),
    .EP_OUT_dataValid_i(wvld), .EP_OUT_data_i(wdat), .EP_OUT_full_o(a_full),
    .gotInToken_i(tok), .EP_OUT_popData_i(pop), .EP_OUT_dataAvailable_o(a_avail),
    .EP_OUT_isLast_o(a_last), .EP_OUT_data_o(a_dat), .hostAck_i(ack),
    .hostTimeout_i(tout), .respValid_o(a_rvld), .respHandshakePID_o(a_rhs),
    .respPacketID_o(a_pid)
  );

  usb_endpoint_out #(.ADDR_WID(4), .MAX_PACKET_SIZE(8), .IS_ISOCHRONOUS(1'b0)) u_dut_b (
    .clk12_i(clk), .rst_n_i(rst_n), .resetDataToggle_i(rtog),
    .EP_OUT_fillTransDone_i(fill_done), .EP_OUT_fillTransSuccess_i(fill_ok),
    .EP_OUT_dataValid_i(wvld), .EP_OUT_data_i(wdat), .EP_OUT_full_o(b_full),
    .gotInToken_i(tok), .EP_OUT_popData_i(pop), .EP_OUT_dataAvailable_o(b_avail),
    .EP_OUT_isLast_o(b_last), .EP_OUT_data_o(b_dat), .hostAck_i(ack),
    .hostTimeout_i(tout), .respValid_o(b_rvld), .respHandshakePID_o(b_rhs),
    .respPacketID_o(b_pid)
  );

  assign o_full  = sel ? b_full  : a_full;
  assign o_avail = sel ? b_avail : a_avail;
  assign o_last  = sel ? b_last  : a_last;
  assign o_rvld  = sel ? b_rvld  : a_rvld;
  assign o_rhs   = sel ? b_rhs   : a_rhs;
  assign o_dat   = sel ? b_dat   : a_dat;
  assign o_pid   = sel ? b_pid   : a_pid;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit model);
    wvld = 1'b1;
    wdat = b;
    tick();
    wvld = 1'b0;
    if (model) exp_q.push_back(b);
  endtask

  task automatic commit(input bit ok);
    fill_done = 1'b1;
    fill_ok   = ok;
    tick();
    fill_done = 1'b0;
    fill_ok   = 1'b0;
  endtask

  task automatic token(input string tag, input bit hs, input logic [1:0] pid);
    int n;
    tok = 1'b1;
    tick();
    tok = 1'b0;
    n = 0;
    while (!o_rvld && n < 4) begin
      tick();
      n++;
    end
    check_eq({tag, "_vld"}, 32'(o_rvld), 1);
    check_eq({tag, "_hs"}, 32'(o_rhs), 32'(hs));
    check_eq({tag, "_pid"}, 32'(o_pid), 32'(pid));
    tick();
    check_eq({tag, "_pulse"}, 32'(o_rvld), 0);
  endtask

  task automatic recv(input string tag, input int n, input int start);
    int w;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!o_avail && w < 8) begin
        tick();
        w++;
      end
      check_eq($sformatf("%s_avail%0d", tag, i), 32'(o_avail), 1);
      check_eq($sformatf("%s_byte%0d", tag, i), 32'(o_dat), 32'(exp_q[start+i]));
      check_eq($sformatf("%s_last%0d", tag, i), 32'(o_last), (i == n - 1) ? 1 : 0);
      pop = 1'b1;
      tick();
      pop = 1'b0;
    end
  endtask

  task automatic handshake(input bit a, input bit t, input bit r);
    ack  = a;
    tout = t;
    rtog = r;
    tick();
    ack  = 1'b0;
    tout = 1'b0;
    rtog = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int w;
    rst_n = 1'b0; rtog = 1'b0; fill_done = 1'b0; fill_ok = 1'b0; wvld = 1'b0;
    wdat = 8'h00; tok = 1'b0; pop = 1'b0; ack = 1'b0; tout = 1'b0; sel = 1'b0;
    repeat (2) tick();

    // Reset state.
    check_eq("rst_rvld", 32'(a_rvld), 0);
    check_eq("rst_rhs", 32'(a_rhs), 0);
    check_eq("rst_pid", 32'(a_pid), 0);
    check_eq("rst_avail", 32'(a_avail), 0);
    check_eq("rst_last", 32'(a_last), 0);
    check_eq("rst_dat", 32'(a_dat), 0);
    check_eq("rst_full", 32'(a_full), 0);
    check_eq("rst_full_b", 32'(b_full), 0);
    rst_n = 1'b1;
    tick();

    // Empty buffer answers NAK.
    token("nak_empty", 1'b1, RES_NAK);

    // Five-byte packet, ACK, then empty again.
    exp_q.delete();
    for (int i = 0; i < 5; i++) write_byte(8'hA0 + 8'(i), 1'b1);
    commit(1'b1);
    token("p5", 1'b0, DATA0);
    recv("p5", 5, 0);
    handshake(1'b1, 1'b0, 1'b0);
    token("p5_nak", 1'b1, RES_NAK);

    // Toggle is now 1: next packet is DATA1.
    exp_q.delete();
    write_byte(8'h5A, 1'b1);
    commit(1'b1);
    token("tog1", 1'b0, DATA1);
    recv("tog1", 1, 0);
    handshake(1'b1, 1'b0, 1'b0);

    // 100 bytes with max 64: timeout, retransmit, ACK, remainder as DATA1.
    exp_q.delete();
    for (int i = 0; i < 100; i++) write_byte(8'(i), 1'b1);
    commit(1'b1);
    token("big1", 1'b0, DATA0);
    recv("big1", 64, 0);
    handshake(1'b0, 1'b1, 1'b0);
    token("big_retry", 1'b0, DATA0);
    recv("big_retry", 64, 0);
    handshake(1'b1, 1'b0, 1'b0);
    token("big2", 1'b0, DATA1);
    recv("big2", 36, 64);
    handshake(1'b1, 1'b0, 1'b0);

    // Discarded fill followed by a one-byte commit.
    exp_q.delete();
    for (int i = 0; i < 3; i++) write_byte(8'h71 + 8'(i), 1'b0);
    commit(1'b0);
    write_byte(8'h11, 1'b1);
    commit(1'b1);
    token("disc", 1'b0, DATA0);
    recv("disc", 1, 0);
    handshake(1'b1, 1'b0, 1'b0);
    token("disc_nak", 1'b1, RES_NAK);

    // ACK together with toggle reset: next packet must be DATA0.
    exp_q.delete();
    write_byte(8'h21, 1'b1);
    write_byte(8'h22, 1'b1);
    commit(1'b1);
    token("rtog_a", 1'b0, DATA1);
    recv("rtog_a", 2, 0);
    handshake(1'b1, 1'b0, 1'b1);
    write_byte(8'h23, 1'b1);
    commit(1'b1);
    token("rtog_b", 1'b0, DATA0);
    recv("rtog_b", 1, 2);
    handshake(1'b1, 1'b0, 1'b0);

    // Reset asserted mid-SEND clears outputs immediately; afterwards the buffer is empty.
    exp_q.delete();
    for (int i = 0; i < 3; i++) write_byte(8'h31 + 8'(i), 1'b1);
    commit(1'b1);
    token("midrst", 1'b0, DATA1);
    w = 0;
    while (!o_avail && w < 8) begin
      tick();
      w++;
    end
    check_eq("midrst_avail_pre", 32'(o_avail), 1);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_avail", 32'(a_avail), 0);
    check_eq("midrst_dat", 32'(a_dat), 0);
    check_eq("midrst_last", 32'(a_last), 0);
    tick();
    rst_n = 1'b1;
    tick();
    token("midrst_nak", 1'b1, RES_NAK);

    // Small instance: full flag, ignored overflow write, wrap-around readback.
    sel = 1'b1;
    exp_q.delete();
    for (int i = 0; i < 14; i++) write_byte(8'h30 + 8'(i), 1'b1);
    check_eq("full_14", 32'(o_full), 0);
    write_byte(8'h3E, 1'b1);
    check_eq("full_15", 32'(o_full), 1);
    write_byte(8'hEE, 1'b0);
    check_eq("full_16", 32'(o_full), 1);
    commit(1'b1);
    token("w1", 1'b0, DATA0);
    recv("w1", 8, 0);
    handshake(1'b1, 1'b0, 1'b0);
    check_eq("full_after_ack", 32'(o_full), 0);
    for (int i = 0; i < 5; i++) write_byte(8'hB0 + 8'(i), 1'b1);
    commit(1'b1);
    token("w2", 1'b0, DATA1);
    recv("w2", 8, 8);
    handshake(1'b1, 1'b0, 1'b0);
    token("w3", 1'b0, DATA0);
    recv("w3", 4, 16);
    handshake(1'b1, 1'b0, 1'b0);
    token("w_nak", 1'b1, RES_NAK);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
